// File: rtl/fu_alu_pipe_pkg.sv
// Shared types for the pipelined integer ALU functional unit: RS/CDB payloads,
// decoded-op encoding, ALU opcode constants and the ROB age test.
package fu_alu_pipe_pkg;

  localparam int ALU_XLEN      = 32;
  localparam int ALU_ROB_DEPTH = 16;
  localparam int ALU_TAG_W     = $clog2(ALU_ROB_DEPTH);
  localparam int ALU_PREG_W    = 7;

  localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OPC_ALU_REG = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SLL  = 4'd3,
    OP_SLT  = 4'd4,
    OP_SLTU = 4'd5,
    OP_XOR  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_OR   = 4'd9,
    OP_AND  = 4'd10,
    OP_LUI  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic [ALU_XLEN-1:0]   imm;
    logic [ALU_PREG_W-1:0] pd;
    logic [ALU_TAG_W-1:0]  rob_index;
  } rs_data;

  typedef struct packed {
    logic [ALU_PREG_W-1:0] p_alu;
    logic [ALU_TAG_W-1:0]  rob_fu_alu;
    logic [ALU_XLEN-1:0]   data;
  } alu_data;

  // Distances are taken modulo ROB_DEPTH by the natural wrap of TAG_W-bit subtraction.
  function automatic logic rob_younger(input logic [ALU_TAG_W-1:0] t,
                                       input logic [ALU_TAG_W-1:0] br,
                                       input logic [ALU_TAG_W-1:0] tail);
    logic [ALU_TAG_W-1:0] d_t;
    logic [ALU_TAG_W-1:0] d_tail;
    d_t    = t - br;
    d_tail = tail - br;
    return (d_t != '0) && (d_t < d_tail);
  endfunction

endpackage

// File: rtl/fu_alu_pipe_alu_core.sv
// Combinational RV32I register/immediate ALU: decode plus execute.
// Unsupported encodings produce zero so the instruction still completes.
module fu_alu_pipe_alu_core
  import fu_alu_pipe_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_func3,
  input  logic            i_alt,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_ps1,
  input  logic [XLEN-1:0] i_ps2,
  output logic [XLEN-1:0] o_result
);

  localparam int SHW = $clog2(XLEN);

  alu_op_e         w_op;
  logic [XLEN-1:0] w_b;
  logic [SHW-1:0]  w_shamt;

  // Decode opcode/func3/func7[5] into an abstract op and pick the second operand
  always_comb begin
    w_op = OP_NONE;
    if (i_opcode == OPC_ALU_IMM) begin
      w_b = i_imm;
    end else begin
      w_b = i_ps2;
    end
    if (i_opcode == OPC_ALU_IMM || i_opcode == OPC_ALU_REG) begin
      case (i_func3)
        3'b000:  w_op = (i_opcode == OPC_ALU_REG && i_alt) ? OP_SUB : OP_ADD;
        3'b001:  w_op = OP_SLL;
        3'b010:  w_op = OP_SLT;
        3'b011:  w_op = OP_SLTU;
        3'b100:  w_op = OP_XOR;
        3'b101:  w_op = i_alt ? OP_SRA : OP_SRL;
        3'b110:  w_op = OP_OR;
        3'b111:  w_op = OP_AND;
        default: w_op = OP_NONE;
      endcase
    end else if (i_opcode == OPC_LUI) begin
      w_op = OP_LUI;
    end else begin
      w_op = OP_NONE;
    end
  end

  // Execute the decoded op; arithmetic wraps modulo 2^XLEN
  always_comb begin
    w_shamt  = w_b[SHW-1:0];
    o_result = '0;
    case (w_op)
      OP_ADD:  o_result = i_ps1 + w_b;
      OP_SUB:  o_result = i_ps1 - w_b;
      OP_SLL:  o_result = i_ps1 << w_shamt;
      OP_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_ps1) < $signed(w_b))};
      OP_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_ps1 < w_b)};
      OP_XOR:  o_result = i_ps1 ^ w_b;
      OP_SRL:  o_result = i_ps1 >> w_shamt;
      OP_SRA:  o_result = $signed(i_ps1) >>> w_shamt;
      OP_OR:   o_result = i_ps1 | w_b;
      OP_AND:  o_result = i_ps1 & w_b;
      OP_LUI:  o_result = i_imm;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/fu_alu_pipe.sv
// Pipelined ALU functional unit: STAGES-deep result pipe with CDB valid/ready
// backpressure (global stall) and age-based squash on branch mispredict.
module fu_alu_pipe
  import fu_alu_pipe_pkg::*;
#(
  parameter int XLEN      = ALU_XLEN,
  parameter int ROB_DEPTH = ALU_ROB_DEPTH,
  parameter int PREG_W    = ALU_PREG_W,
  parameter int STAGES    = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_issue_valid,
  output logic                         o_issue_ready,
  input  rs_data                       i_data_in,
  input  logic [XLEN-1:0]              i_ps1_data,
  input  logic [XLEN-1:0]              i_ps2_data,
  input  logic                         i_mispredict,
  input  logic [$clog2(ROB_DEPTH)-1:0] i_mispredict_tag,
  input  logic [$clog2(ROB_DEPTH)-1:0] i_curr_rob_tag,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output alu_data                      o_data_out
);

  localparam int TAG_W = $clog2(ROB_DEPTH);

  logic              r_v    [STAGES];
  logic [PREG_W-1:0] r_pd   [STAGES];
  logic [TAG_W-1:0]  r_rob  [STAGES];
  logic [XLEN-1:0]   r_data [STAGES];

  logic              w_kill [STAGES];
  logic              w_adv;
  logic              w_accept;
  logic [XLEN-1:0]   w_result;

  fu_alu_pipe_alu_core #(.XLEN(XLEN)) u_core (
    .i_opcode (i_data_in.opcode),
    .i_func3  (i_data_in.func3),
    .i_alt    (i_data_in.func7[5]),
    .i_imm    (i_data_in.imm),
    .i_ps1    (i_ps1_data),
    .i_ps2    (i_ps2_data),
    .o_result (w_result)
  );

  // Per-stage squash decision for the current mispredict pulse
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      w_kill[i] = i_mispredict && rob_younger(r_rob[i], i_mispredict_tag, i_curr_rob_tag);
    end
  end

  // Handshake: a killed head is hidden from the CDB but still occupies the slot
  always_comb begin
    w_adv         = !r_v[STAGES-1] || i_out_ready;
    o_issue_ready = w_adv && !i_mispredict;
    w_accept      = i_issue_valid && o_issue_ready;
    o_out_valid   = r_v[STAGES-1] && !w_kill[STAGES-1];
  end

  assign o_data_out = {r_pd[STAGES-1], r_rob[STAGES-1], r_data[STAGES-1]};

  // Pipeline registers: shift on advance, otherwise hold; kills clear valid either way
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_v[i]    <= 1'b0;
        r_pd[i]   <= '0;
        r_rob[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (w_adv) begin
      r_v[0]    <= w_accept;
      r_pd[0]   <= i_data_in.pd;
      r_rob[0]  <= i_data_in.rob_index;
      r_data[0] <= w_result;
      for (int i = 1; i < STAGES; i++) begin
        r_v[i]    <= r_v[i-1] && !w_kill[i-1];
        r_pd[i]   <= r_pd[i-1];
        r_rob[i]  <= r_rob[i-1];
        r_data[i] <= r_data[i-1];
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= r_v[i] && !w_kill[i];
      end
    end
  end

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Self-checking bench for fu_alu_pipe: directed ALU vectors, backpressure,
// wrap-around flush, async reset, and randomized traffic against a queue model.
module tb_fu_alu_pipe;
  import fu_alu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  rs_data      data_in;
  logic [31:0] ps1;
  logic [31:0] ps2;
  logic        mispredict;
  logic [3:0]  mp_tag;
  logic [3:0]  curr_tag;
  logic        out_valid;
  logic        out_ready;
  alu_data     data_out;

  int n_cmp = 0;
  int n_err = 0;
  alu_data q[$];

  // mnemonic index: 0..8 I-type, 9..18 R-type, 19 LUI, 20 unsupported
  localparam int F3_I [9]  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
  localparam int F3_R [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

  fu_alu_pipe #(.STAGES(2)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_issue_valid    (issue_valid),
    .o_issue_ready    (issue_ready),
    .i_data_in        (data_in),
    .i_ps1_data       (ps1),
    .i_ps2_data       (ps2),
    .i_mispredict     (mispredict),
    .i_mispredict_tag (mp_tag),
    .i_curr_rob_tag   (curr_tag),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_data_out       (data_out)
  );

  always #5 clk = ~clk;

  function automatic rs_data encode(input int m, input logic [31:0] imm,
                                    input logic [6:0] pd, input logic [3:0] rob);
    rs_data d;
    d.imm = imm; d.pd = pd; d.rob_index = rob; d.func7 = 7'd0; d.func3 = 3'd0;
    if (m < 9) begin
      d.opcode = 7'b0010011; d.func3 = 3'(F3_I[m]); d.func7[5] = (m == 8);
    end else if (m < 19) begin
      d.opcode = 7'b0110011; d.func3 = 3'(F3_R[m-9]); d.func7[5] = (m == 10 || m == 16);
    end else if (m == 19) begin
      d.opcode = 7'b0110111;
    end else begin
      d.opcode = 7'b1100011;
    end
    return d;
  endfunction

  function automatic logic [31:0] ref_result(input int m, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] imm);
    logic signed [31:0] sa, sb, si;
    sa = a; sb = b; si = imm;
    case (m)
      0:  return a + imm;
      1:  return (sa < si) ? 32'd1 : 32'd0;
      2:  return (a < imm) ? 32'd1 : 32'd0;
      3:  return a ^ imm;
      4:  return a | imm;
      5:  return a & imm;
      6:  return a << imm[4:0];
      7:  return a >> imm[4:0];
      8:  return 32'(sa >>> imm[4:0]);
      9:  return a + b;
      10: return a - b;
      11: return a << b[4:0];
      12: return (sa < sb) ? 32'd1 : 32'd0;
      13: return (a < b) ? 32'd1 : 32'd0;
      14: return a ^ b;
      15: return a >> b[4:0];
      16: return 32'(sa >>> b[4:0]);
      17: return a | b;
      18: return a & b;
      19: return imm;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit tb_younger(input int t, input int br, input int tl);
    return (((t - br) & 15) != 0) && (((t - br) & 15) < ((tl - br) & 15));
  endfunction

  task automatic set_issue(input int m, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [6:0] pd, input logic [3:0] rob);
    data_in = encode(m, imm, pd, rob);
    ps1 = a; ps2 = b; issue_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid = 1'b0; data_in = '0; ps1 = 32'd0; ps2 = 32'd0;
    mispredict = 1'b0; mp_tag = 4'd0; curr_tag = 4'd0; out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (data_out !== alu_data'(0)) begin n_err++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_alu_ops();
    int          vm   [7] = '{16, 13, 2, 19, 20, 10, 12};
    logic [31:0] va   [7] = '{32'h8000_0000, 32'd1, 32'd5, 32'd0, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] vb   [7] = '{32'h24, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd9, 32'd1, 32'd1};
    logic [31:0] vi   [7] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'h1234_5000, 32'd3, 32'd0, 32'd0};
    logic [31:0] vexp [7] = '{32'hF800_0000, 32'd1, 32'd1, 32'h1234_5000, 32'd0, 32'hFFFF_FFFF, 32'd1};
    alu_data exp_d;
    out_ready = 1'b1;
    // ADDI latency check: 0xFFFF_FFFF + 1 wraps to 0
    @(posedge clk); #1; set_issue(0, 32'hFFFF_FFFF, 32'd0, 32'd1, 7'd5, 4'd0);
    @(posedge clk); #1; issue_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL addi_early: out_valid %b want 0", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: out_valid %b want 1", out_valid); end
    exp_d = '{p_alu: 7'd5, rob_fu_alu: 4'd0, data: 32'd0};
    n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL addi_data: got %h want %h", data_out, exp_d); end
    // Back-to-back directed vectors; result k visible two cycles after issue k
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (k < 7) set_issue(vm[k], va[k], vb[k], vi[k], 7'(10 + k), 4'(k));
      else issue_valid = 1'b0;
      @(negedge clk);
      if (k >= 2) begin
        exp_d = '{p_alu: 7'(10 + k - 2), rob_fu_alu: 4'(k - 2), data: vexp[k-2]};
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL vec%0d_valid: got %b want 1", k - 2, out_valid); end
        n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL vec%0d_data: got %h want %h", k - 2, data_out, exp_d); end
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int m;
    logic [31:0] a, b, imm;
    q.delete();
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 5);
      if (idx < 4) begin
        m = $urandom_range(0, 18); a = $urandom; b = $urandom; imm = {{20{a[5]}}, b[11:0]};
        set_issue(m, a, b, imm, 7'(60 + idx), 4'(idx));
      end else begin
        issue_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc < 5) begin
        n_cmp++; if (issue_ready !== (cyc < 2)) begin n_err++; $display("FAIL bp_issue_ready cyc%0d: got %b want %b", cyc, issue_ready, (cyc < 2)); end
      end
      if (cyc >= 2 && cyc < 5) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cyc%0d: got %b want 1", cyc, out_valid); end
      end
      if (out_valid) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL bp_spurious: got %h want nothing", data_out); end
        else begin
          if (data_out !== q[0]) begin n_err++; $display("FAIL bp_order: got %h want %h", data_out, q[0]); end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (issue_valid && issue_ready) begin
        q.push_back('{p_alu: data_in.pd, rob_fu_alu: data_in.rob_index, data: ref_result(m, a, b, imm)});
        idx++;
      end
    end
    n_cmp++; if (idx !== 4 || q.size() !== 0) begin n_err++; $display("FAIL bp_complete: issued %0d left %0d want 4/0", idx, q.size()); end
  endtask

  task automatic run_flush(input int sc, input logic [3:0] ta, input logic [3:0] tb2,
                           input logic [3:0] br, input logic [3:0] tl, input bit keep_a, input bit keep_b);
    logic [31:0] a0, b0, a1, b1;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    q.delete();
    out_ready = 1'b0;
    @(posedge clk); #1; set_issue(9, a0, b0, 32'd0, 7'd20, ta);
    q.push_back('{p_alu: 7'd20, rob_fu_alu: ta, data: a0 + b0});
    @(posedge clk); #1; set_issue(9, a1, b1, 32'd0, 7'd21, tb2);
    q.push_back('{p_alu: 7'd21, rob_fu_alu: tb2, data: a1 + b1});
    @(posedge clk); #1; issue_valid = 1'b0; mispredict = 1'b1; mp_tag = br; curr_tag = tl;
    @(negedge clk);
    n_cmp++; if (out_valid !== keep_a) begin n_err++; $display("FAIL flush%0d_head_gate: got %b want %b", sc, out_valid, keep_a); end
    n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL flush%0d_issue_ready: got %b want 0", sc, issue_ready); end
    if (!keep_b) q.delete(1);
    if (!keep_a) q.delete(0);
    @(posedge clk); #1; mispredict = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL flush%0d_squashed_out: got %h want nothing", sc, data_out); end
        else begin
          if (data_out !== q[0]) begin n_err++; $display("FAIL flush%0d_survivor: got %h want %h", sc, data_out, q[0]); end
          void'(q.pop_front());
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (q.size() !== 0) begin n_err++; $display("FAIL flush%0d_lost: %0d survivors missing want 0", sc, q.size()); end
  endtask

  task automatic test_flush();
    run_flush(0, 4'd15, 4'd1,  4'd14, 4'd2, 1'b0, 1'b0);
    run_flush(1, 4'd14, 4'd3,  4'd14, 4'd2, 1'b1, 1'b1);
    run_flush(2, 4'd14, 4'd15, 4'd14, 4'd2, 1'b1, 1'b0);
    run_flush(3, 4'd6,  4'd7,  4'd5,  4'd5, 1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    alu_data exp_d;
    out_ready = 1'b0;
    @(posedge clk); #1; set_issue(9, 32'd1, 32'd2, 32'd0, 7'd30, 4'd3);
    @(posedge clk); #1; set_issue(9, 32'd3, 32'd4, 32'd0, 7'd31, 4'd4);
    @(posedge clk); #1; issue_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ar_full: out_valid %b want 1", out_valid); end
    @(posedge clk); #2; rst_n = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (data_out !== alu_data'(0)) begin n_err++; $display("FAIL ar_data_out: got %h want 0", data_out); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL ar_issue_ready: got %b want 1", issue_ready); end
    #1; rst_n = 1'b1;
    q.delete();
    @(posedge clk); #1; set_issue(10, 32'd10, 32'd3, 32'd0, 7'd40, 4'd5); out_ready = 1'b1;
    @(posedge clk); #1; issue_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_stale: out_valid %b want 0", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    exp_d = '{p_alu: 7'd40, rob_fu_alu: 4'd5, data: 32'd7};
    n_cmp++; if (out_valid !== 1'b1 || data_out !== exp_d) begin n_err++; $display("FAIL ar_first_issue: got %b/%h want 1/%h", out_valid, data_out, exp_d); end
  endtask

  task automatic test_random();
    logic [3:0]  rob_tail = 4'd0;
    logic [3:0]  br;
    int          m;
    logic [31:0] a, b, imm, r;
    q.delete();
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 690) begin
        out_ready = ($urandom_range(0, 3) != 0);
        mispredict = ($urandom_range(0, 11) == 0);
        issue_valid = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1; mispredict = 1'b0; issue_valid = 1'b0;
      end
      curr_tag = rob_tail;
      if (mispredict) begin
        br = rob_tail - 4'($urandom_range(1, 4));
        mp_tag = br;
        for (int i = q.size() - 1; i >= 0; i--)
          if (tb_younger(int'(q[i].rob_fu_alu), int'(br), int'(rob_tail))) q.delete(i);
        rob_tail = br + 4'd1;
      end
      m = $urandom_range(0, 20); a = $urandom; b = $urandom; r = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h1F;
      imm = (m == 19) ? {r[19:0], 12'h000} : {{20{r[11]}}, r[11:0]};
      data_in = encode(m, imm, 7'(r[31:25]), rob_tail); ps1 = a; ps2 = b;
      @(negedge clk);
      if (mispredict) begin
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL rnd_flush_ready cyc%0d: got %b want 0", cyc, issue_ready); end
      end
      if (out_valid) begin
        n_cmp++;
        if (q.size() == 0) begin n_err++; $display("FAIL rnd_spurious cyc%0d: got %h want nothing", cyc, data_out); end
        else begin
          if (data_out !== q[0]) begin n_err++; $display("FAIL rnd_result cyc%0d: got %h want %h", cyc, data_out, q[0]); end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (issue_valid && issue_ready) begin
        q.push_back('{p_alu: data_in.pd, rob_fu_alu: rob_tail, data: ref_result(m, a, b, imm)});
        rob_tail = rob_tail + 4'd1;
      end
    end
    n_cmp++; if (q.size() !== 0) begin n_err++; $display("FAIL rnd_drain: %0d results missing want 0", q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
